// File: rtl/irq_ctrl.sv
// External interrupt controller: per-source level/edge gateways, pending and in-service
// tracking, fixed-priority claim/complete, and the registered request to the CSR file.
`timescale 1ns/1ps
module irq_ctrl #(
    parameter int N_SRC       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_addr,
    input  logic             req_wena,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    input  logic [N_SRC-1:0] irq_src,
    output logic             int_req
);

    localparam logic [2:0] A_PENDING = 3'd0;
    localparam logic [2:0] A_ENABLE  = 3'd1;
    localparam logic [2:0] A_TRIGGER = 3'd2;
    localparam logic [2:0] A_CLAIM   = 3'd3;
    localparam logic [2:0] A_SWSET   = 3'd4;
    localparam logic [2:0] A_INSERV  = 3'd5;

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] trigger_q, trigger_d;
    logic [N_SRC-1:0] in_service_q, in_service_d;
    logic [N_SRC-1:0] src_prev_q, src_prev_d;
    logic             int_req_q, int_req_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] edge_evt;
    logic [N_SRC-1:0] gw_set;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] claim_oh;
    logic [N_SRC-1:0] complete_oh;
    logic [N_SRC-1:0] swset_mask;
    logic [5:0]       best_idx;
    logic             any_elig;
    logic [2:0]       sel;
    logic             rd_acc;
    logic             wr_acc;
    logic             claim_acc;
    logic             complete_acc;
    logic [5:0]       complete_id;
    logic [33:0]      unused_bits;

    assign req_ready    = 1'b1;
    assign sel          = req_addr[4:2];
    assign rd_acc       = req_valid & ~req_wena;
    assign wr_acc       = req_valid & req_wena;
    assign claim_acc    = rd_acc && (sel == A_CLAIM);
    assign complete_acc = wr_acc && (sel == A_CLAIM);
    assign complete_id  = req_wdata[5:0];
    assign swset_mask   = (wr_acc && (sel == A_SWSET)) ? req_wdata[N_SRC-1:0] : '0;
    assign unused_bits  = {req_addr[1:0], req_wdata};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign src_s = irq_src;
        end else begin : g_sync
            logic [N_SRC-1:0] sync_q [SYNC_STAGES];
            logic [N_SRC-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = irq_src;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_d[s] = sync_q[s-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign src_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Per-source gateway; IDs outside 1..N_SRC never match a complete and are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign edge_evt[gi]    = src_s[gi] & ~src_prev_q[gi];
            assign gw_set[gi]      = trigger_q[gi] ? edge_evt[gi]
                                                   : (src_s[gi] & ~in_service_q[gi]);
            assign eligible[gi]    = pending_q[gi] & enable_q[gi] & ~in_service_q[gi];
            assign claim_oh[gi]    = claim_acc && any_elig && (best_idx == 6'(gi));
            assign complete_oh[gi] = complete_acc && (complete_id == 6'(gi + 1));
        end
    endgenerate

    // Lowest index wins: scan downward so the last hit is the smallest one.
    always_comb begin
        any_elig = 1'b0;
        best_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any_elig = 1'b1;
                best_idx = 6'(i);
            end
        end
    end

    always_comb begin
        // A set in the same cycle as a claim clear wins, so no event is dropped.
        pending_d    = (pending_q & ~claim_oh) | gw_set | swset_mask;
        in_service_d = (in_service_q | claim_oh) & ~complete_oh;
        enable_d     = (wr_acc && (sel == A_ENABLE))  ? req_wdata[N_SRC-1:0] : enable_q;
        trigger_d    = (wr_acc && (sel == A_TRIGGER)) ? req_wdata[N_SRC-1:0] : trigger_q;
        src_prev_d   = src_s;
        int_req_d    = any_elig;
        rsp_valid_d  = req_valid;
        rsp_err_d    = req_valid && (sel[2:1] == 2'b11);
        rsp_rdata_d  = '0;
        if (rd_acc) begin
            case (sel)
                A_PENDING: rsp_rdata_d = 32'(pending_q);
                A_ENABLE:  rsp_rdata_d = 32'(enable_q);
                A_TRIGGER: rsp_rdata_d = 32'(trigger_q);
                A_CLAIM:   rsp_rdata_d = any_elig ? (32'(best_idx) + 32'd1) : 32'd0;
                A_INSERV:  rsp_rdata_d = 32'(in_service_q);
                default:   rsp_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q    <= '0;
            enable_q     <= '0;
            trigger_q    <= '0;
            in_service_q <= '0;
            src_prev_q   <= '0;
            int_req_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            trigger_q    <= trigger_d;
            in_service_q <= in_service_d;
            src_prev_q   <= src_prev_d;
            int_req_q    <= int_req_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign int_req   = int_req_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, every cycle compared
// against a rule-level reference model of the controller.
`timescale 1ns/1ps
module tb_irq_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic        req_wena;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] irq_src;
    logic        int_req;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.N_SRC(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wena(req_wena), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .irq_src(irq_src), .int_req(int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit [31:0] m_pend, m_en, m_trig, m_ins;
    bit [31:0] m_rd;
    bit        m_rv, m_err, m_int;
    bit [31:0] m_hist [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pend = 0; m_en = 0; m_trig = 0; m_ins = 0;
        m_rd = 0; m_rv = 0; m_err = 0; m_int = 0;
        for (int k = 0; k < 3; k++) m_hist[k] = 0;
    endtask

    // One clock edge of the controller, computed from the behavioural rules.
    task automatic model_edge(input bit v, input bit [4:0] a, input bit w,
                              input bit [31:0] d, input bit [31:0] src);
        bit [31:0] elig, src_s, prev, setv, sw, n_pend, n_ins, n_en, n_trig;
        int best, id, reg_no;
        elig = m_pend & m_en & ~m_ins;
        best = -1;
        for (int i = 0; i < 32; i++) if (elig[i] && best < 0) best = i;
        src_s = m_hist[1];
        prev  = m_hist[2];
        for (int i = 0; i < 32; i++)
            setv[i] = m_trig[i] ? (src_s[i] && !prev[i]) : (src_s[i] && !m_ins[i]);
        n_pend = m_pend; n_ins = m_ins; n_en = m_en; n_trig = m_trig; sw = 0;
        reg_no = int'(a) / 4;
        m_rv  = v;
        m_err = v && reg_no >= 6;
        m_rd  = 0;
        if (v && !w) begin
            if (reg_no == 0) m_rd = m_pend;
            else if (reg_no == 1) m_rd = m_en;
            else if (reg_no == 2) m_rd = m_trig;
            else if (reg_no == 5) m_rd = m_ins;
            else if (reg_no == 3 && best >= 0) begin
                m_rd = best + 1;
                n_pend[best] = 1'b0;
                n_ins[best]  = 1'b1;
            end
        end
        if (v && w) begin
            if (reg_no == 1) n_en = d;
            else if (reg_no == 2) n_trig = d;
            else if (reg_no == 4) sw = d;
            else if (reg_no == 3) begin
                id = int'(d[5:0]);
                if (id >= 1 && id <= 32) n_ins[id-1] = 1'b0;
            end
        end
        m_pend = n_pend | setv | sw;
        m_ins  = n_ins;
        m_en   = n_en;
        m_trig = n_trig;
        m_int  = (elig != 0);
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = src;
    endtask

    task automatic step(input bit v, input bit [4:0] a, input bit w, input bit [31:0] d);
        req_valid = v; req_addr = a; req_wena = w; req_wdata = d;
        model_edge(v, a, w, d, irq_src);
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_err",   32'(rsp_err),   32'(m_err));
        chk("rsp_rdata", rsp_rdata,      m_rd);
        chk("int_req",   32'(int_req),   32'(m_int));
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'h0, 1'b0, 32'h0);
    endtask

    task automatic rd(input bit [4:0] a, output bit [31:0] q);
        step(1'b1, a, 1'b0, 32'h0);
        q = rsp_rdata;
    endtask

    task automatic wr(input bit [4:0] a, input bit [31:0] d);
        step(1'b1, a, 1'b1, d);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        irq_src = '0;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_int_req",   32'(int_req),   32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit [31:0] q;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wena = 1'b0;
        req_wdata = '0; irq_src = '0;
        model_clear();
        #12;
        do_reset();

        // Reset values
        rd(5'h04, q); chk("rst_enable", q, 32'h0);
        rd(5'h00, q); chk("rst_pending", q, 32'h0);
        rd(5'h14, q); chk("rst_inserv", q, 32'h0);
        rd(5'h0C, q); chk("rst_claim", q, 32'h0);
        chk("rst_err_read", 32'(rsp_err), 32'h0);

        // Level sources 0 and 2
        wr(5'h04, 32'h5);
        irq_src = 32'h5;
        idle(3);
        chk("lvl_int_early", 32'(int_req), 32'h0);
        idle(1);
        chk("lvl_int_lat4", 32'(int_req), 32'h1);
        rd(5'h0C, q); chk("lvl_claim1", q, 32'd1);
        rd(5'h0C, q); chk("lvl_claim3", q, 32'd3);
        idle(1);
        chk("lvl_int_drop", 32'(int_req), 32'h0);
        wr(5'h0C, 32'd1);
        rd(5'h00, q); chk("lvl_repend", 32'(q[0]), 32'h1);
        rd(5'h0C, q); chk("lvl_reclaim1", q, 32'd1);

        // Edge source 4
        do_reset();
        wr(5'h08, 32'h10);
        wr(5'h04, 32'h10);
        irq_src = 32'h10; idle(1); irq_src = 32'h0; idle(3);
        rd(5'h00, q); chk("edge_pend", q, 32'h10);
        rd(5'h0C, q); chk("edge_claim5", q, 32'd5);
        rd(5'h00, q); chk("edge_pend_clr", q, 32'h0);
        irq_src = 32'h10; idle(1); irq_src = 32'h0; idle(3);
        rd(5'h00, q); chk("edge_pend_insv", q, 32'h10);
        rd(5'h0C, q); chk("edge_claim_blocked", q, 32'd0);
        wr(5'h0C, 32'd5);
        rd(5'h0C, q); chk("edge_claim_again", q, 32'd5);

        // Edge on source 1 coinciding with its claim
        do_reset();
        wr(5'h08, 32'h2);
        wr(5'h04, 32'h2);
        wr(5'h10, 32'h2);
        irq_src = 32'h2; idle(1); irq_src = 32'h0; idle(1);
        rd(5'h0C, q); chk("race_claim2", q, 32'd2);
        rd(5'h00, q); chk("race_pend_kept", q, 32'h2);
        rd(5'h14, q); chk("race_inserv", q, 32'h2);

        // SWSET with and without enable
        do_reset();
        wr(5'h10, 32'h80);
        rd(5'h00, q); chk("sw_pend", q, 32'h80);
        chk("sw_int_masked", 32'(int_req), 32'h0);
        wr(5'h04, 32'h80);
        idle(1);
        chk("sw_int_on", 32'(int_req), 32'h1);
        rd(5'h0C, q); chk("sw_claim8", q, 32'd8);

        // Unmapped, bad completes, ignored write, back-to-back reads
        rd(5'h1C, q); chk("unmap_rdata", q, 32'h0);
        chk("unmap_err", 32'(rsp_err), 32'h1);
        wr(5'h0C, 32'd0);
        wr(5'h0C, 32'd40);
        rd(5'h14, q); chk("badcmp_inserv", q, 32'h80);
        wr(5'h00, 32'hFFFF_FFFF);
        chk("ro_write_err", 32'(rsp_err), 32'h0);
        rd(5'h00, q); chk("b2b_pend0", q, 32'h0);
        chk("b2b_valid0", 32'(rsp_valid), 32'h1);
        rd(5'h00, q); chk("b2b_valid1", 32'(rsp_valid), 32'h1);

        // Request in flight when reset hits
        req_valid = 1'b1; req_addr = 5'h00; req_wena = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Random traffic against the model
        wr(5'h08, $urandom);
        wr(5'h04, $urandom | $urandom);
        for (int n = 0; n < 800; n++) begin
            int op;
            if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ (32'h1 << $urandom_range(0, 31));
            op = int'($urandom_range(0, 9));
            if (op <= 3) step(1'b1, 5'h0C, 1'b0, 32'h0);
            else if (op == 4) step(1'b1, 5'h0C, 1'b1, 32'($urandom_range(0, 40)));
            else if (op == 5) step(1'b1, 5'($urandom), 1'b0, 32'h0);
            else if (op == 6) step(1'b1, 5'h10, 1'b1, $urandom & $urandom & $urandom);
            else if (op == 7) step(1'b1, 5'($urandom_range(1, 2) * 4), 1'b1, $urandom);
            else if (op == 8) step(1'b1, 5'($urandom), 1'b1, $urandom);
            else idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped external interrupt controller for the core. It collects up to N_SRC peripheral interrupt lines and runs a per-source gateway (level or edge).
- It tracks pending and in-service state and provides a claim/complete register pair.
- It drives the single machine external interrupt request into the CSR file (int_req_ictrl, i.e. mip.MEIP).
- Software claims the highest-priority source from the trap handler and completes it once serviced.

Parameters:
N_SRC, 32, number of interrupt sources (1..32); source i has ID i+1, ID 0 means "none".
SYNC_STAGES, 2, flip-flop synchronizer depth on irq_src (0 = inputs already synchronous).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  bus request valid
req_ready  output  1  bus request accepted; constant 1
req_addr  input  5  byte address; bits [4:2] select register, bits [1:0] ignored
req_wena  input  1  1 = write, 0 = read
req_wdata  input  32  write data
rsp_valid  output  1  response valid, exactly one cycle after an accepted request
rsp_rdata  output  32  registered read data (0 for writes)
rsp_err  output  1  unmapped address, qualified by rsp_valid
irq_src  input  N_SRC  raw interrupt lines from peripherals
int_req  output  1  to CSR file int_req_ictrl; registered

Behaviour:
- Reset: all of the following are 0: pending, enable, trigger, in_service, sync/edge flops, rsp_valid, rsp_rdata, rsp_err, int_req.
- Register map (word offset: name, access):
  - 0x00 PENDING, RO; writes are ignored, no error.
  - 0x04 ENABLE, RW.
  - 0x08 TRIGGER, RW; 1 = rising-edge source, 0 = level-high source.
  - 0x0C CLAIM/COMPLETE: read = claim; write wdata[5:0] = complete ID.
  - 0x10 SWSET, WO; a 1 in bit i sets pending[i]. Reads return 0.
  - 0x14 IN_SERVICE, RO.
  - 0x18..0x1C unmapped: rsp_err = 1, read data 0, no state change.
  - Bits >= N_SRC read as 0 and are not writable.
- Synchronizer: src_s = irq_src delayed SYNC_STAGES cycles. Edge event = src_s & ~src_s_prev.
- Gateway set condition per cycle:
  - Edge source: edge event.
  - Level source: src_s[i] && !in_service[i].
  - The set condition applies regardless of ENABLE; ENABLE only masks requests and claims.
- Eligibility: eligible[i] = pending[i] & enable[i] & ~in_service[i].
  - best = lowest i with eligible[i]. Fixed priority: lower index wins.
- Claim (accepted read of 0x0C):
  - rsp_rdata = best+1, or 0 if nothing is eligible.
  - Next cycle: pending[best] = 0 and in_service[best] = 1.
  - A claim returning 0 changes nothing.
- Complete (accepted write to 0x0C):
  - ID in 1..N_SRC clears in_service[ID-1].
  - ID 0 or ID > N_SRC is ignored; rsp_err stays 0.
  - Completing a source that is not in service is a no-op.
- Simultaneous events on the same source in one cycle:
  - Claim clear and gateway/SWSET set: set wins. An edge arriving during a claim is not lost.
  - Complete and level source still high: in_service clears this cycle; pending re-sets the following cycle.
  - An edge arriving while in service: pending is set and the source is claimable again only after complete.
- int_req: registered |eligible, so it asserts 1 cycle after eligible becomes nonzero.
  - Latency from an irq_src edge to int_req is SYNC_STAGES+2 cycles: SYNC_STAGES synchronizer + 1 pending + 1 int_req.
  - It deasserts the cycle after the claim updates state.
- Register writes (ENABLE, TRIGGER, SWSET) take effect the cycle after acceptance.
- Changing TRIGGER does not clear pending.
- Bus: one request per cycle, back-to-back allowed, no wait states. rsp_valid mirrors the previous cycle's req_valid.
- Reset mid-operation: all state clears immediately (asynchronous). A request in flight produces no response.

Test Plan:
- Reset, then read ENABLE, PENDING, IN_SERVICE, CLAIM -> all return 0; int_req = 0; rsp_err = 0.
- Level, ENABLE = 0x5, irq_src[0] and [2] held high -> int_req asserts 4 cycles after src rises (SYNC_STAGES=2).
  - Claim returns 1; next claim returns 3; int_req drops.
  - Complete 1 with src[0] still high -> PENDING bit 0 set 1 cycle after complete; claim returns 1 again.
- Edge source 4 (TRIGGER = 0x10, ENABLE = 0x10), single 1-cycle pulse -> PENDING = 0x10.
  - Claim returns 5 and PENDING = 0.
  - A second pulse while in service -> PENDING = 0x10 but claim returns 0 until complete 5, after which claim returns 5.
- Edge on source 1 lands in the same cycle as its claim clear -> pending[1] = 1 afterwards; no event lost.
- SWSET write 0x80 with ENABLE = 0 -> PENDING = 0x80 and int_req = 0. Set ENABLE = 0x80 -> int_req = 1; claim returns 8.
- Read 0x1C -> rsp_err = 1 and rdata = 0.
  - Complete 0 and complete 40 -> no state change.
  - Back-to-back reads of PENDING -> rsp_valid high on consecutive cycles.
